// File: rtl/udp_rx_pkg.sv
// Shared types for the UDP receive packet buffer.
// Descriptor layout, FSM encodings and the drop counter ceiling.
package udp_rx_pkg;

  localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic [15:0] len;
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] wcnt;
  } desc_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_RECV,
    W_DROP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_STREAM
  } rstate_e;

endpackage

// File: rtl/udp_rx_buffer_if.sv
// Decoder-side write bundle and application-side read bundle.
// master drives the buffer inputs, slave is the buffer itself.
interface udp_rx_buffer_if;

  logic [31:0] data_udp_out;
  logic        wr_en_udp;
  logic [15:0] len_udp_data;
  logic [15:0] src_port_udp;
  logic [15:0] dest_port_udp;
  logic        ok_udp;
  logic        fin_udp;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_last;
  logic [15:0] rd_len;
  logic [15:0] rd_src_port;
  logic [15:0] rd_dest_port;
  logic        pkt_avail;
  logic [15:0] drop_cnt;

  modport master (
    output data_udp_out, wr_en_udp,
    output len_udp_data, src_port_udp,
    output dest_port_udp, ok_udp,
    output fin_udp, rd_en,
    input  rd_data, rd_valid, rd_last,
    input  rd_len, rd_src_port,
    input  rd_dest_port, pkt_avail,
    input  drop_cnt
  );

  modport slave (
    input  data_udp_out, wr_en_udp,
    input  len_udp_data, src_port_udp,
    input  dest_port_udp, ok_udp,
    input  fin_udp, rd_en,
    output rd_data, rd_valid, rd_last,
    output rd_len, rd_src_port,
    output rd_dest_port, pkt_avail,
    output drop_cnt
  );

endinterface

// File: rtl/udp_rx_desc_fifo.sv
// Show-ahead FIFO of committed packet descriptors.
// head_o reads as zero whenever the FIFO is empty.
module udp_rx_desc_fifo
  import udp_rx_pkg::*;
#(
  parameter int DESC_LOG2 = 3
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push_i,
  input  desc_t din_i,
  input  logic  pop_i,
  output logic  full_o,
  output logic  empty_o,
  output desc_t head_o
);

  localparam int N = 1 << DESC_LOG2;
  localparam logic [DESC_LOG2:0] ONE = 1;
  localparam logic [DESC_LOG2:0] CAP =
    {1'b1, {DESC_LOG2{1'b0}}};

  desc_t              mem_q [N];
  logic [DESC_LOG2:0] wptr_q;
  logic [DESC_LOG2:0] rptr_q;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = ((wptr_q - rptr_q) == CAP);
  assign head_o  = empty_o ? '0
                 : mem_q[rptr_q[DESC_LOG2-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else begin
      if (push_i && !full_o) begin
        mem_q[wptr_q[DESC_LOG2-1:0]] <= din_i;
        wptr_q <= wptr_q + ONE;
      end
      if (pop_i && !empty_o) rptr_q <= rptr_q + ONE;
    end
  end

endmodule

// File: rtl/udp_rx_buffer.sv
// UDP payload buffer: speculative write, commit/rollback on fin.
// Optional dest-port filter: define UDP_RX_PORT_FILTER_EN.
module udp_rx_buffer
  import udp_rx_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 9,
  parameter int          DESC_LOG2  = 3,
  parameter logic [15:0] LOCAL_PORT = 16'h2694
) (
  input logic      clk,
  input logic      reset,
  udp_rx_buffer_if.slave bus
);

  localparam int PW = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] ONE = 1;
  localparam logic [PW-1:0] RAM_WORDS =
    {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [31:0]   ram_q [2**DEPTH_LOG2];

  wstate_e       wstate_q;
  logic [PW-1:0] spec_ptr_q;
  logic [PW-1:0] commit_ptr_q;
  logic [PW-1:0] wcnt_q;
  logic [15:0]   drop_cnt_q;

  rstate_e       rstate_q;
  logic [PW-1:0] rd_ptr_q;
  logic [15:0]   rcnt_q;
  logic [31:0]   rd_data_q;
  logic          rd_valid_q;
  logic          rd_last_q;

  logic          ram_full;
  logic          wr_live;
  logic          wr_store;
  logic          wr_ovf;
  logic [PW-1:0] spec_n;
  logic [PW-1:0] wcnt_n;
  logic          bad_n;
  logic          port_ok;
  logic          commit;
  desc_t         push_desc;

  logic          desc_full;
  logic          desc_empty;
  desc_t         head;
  logic          rd_fire;
  logic [15:0]   remain;
  logic          pop;

`ifdef UDP_RX_PORT_FILTER_EN
  assign port_ok = (bus.dest_port_udp == LOCAL_PORT);
`else
  // every destination port passes
  assign port_ok = 1'b1 | (bus.dest_port_udp == LOCAL_PORT);
`endif

  // fin sees the word written in the same cycle
  always_comb begin
    ram_full  = ((spec_ptr_q - rd_ptr_q) == RAM_WORDS);
    wr_live   = bus.wr_en_udp && (wstate_q != W_DROP);
    wr_store  = wr_live && !ram_full;
    wr_ovf    = wr_live && ram_full;
    spec_n    = spec_ptr_q + (wr_store ? ONE : '0);
    wcnt_n    = wcnt_q + (wr_store ? ONE : '0);
    bad_n     = (wstate_q == W_DROP) || wr_ovf;
    commit    = bus.fin_udp && bus.ok_udp && port_ok
             && !bad_n && !desc_full;
    push_desc = '{len:  bus.len_udp_data,
                  src:  bus.src_port_udp,
                  dst:  bus.dest_port_udp,
                  wcnt: 16'(wcnt_n)};
  end

  always_ff @(posedge clk) begin
    if (wr_store)
      ram_q[spec_ptr_q[DEPTH_LOG2-1:0]] <= bus.data_udp_out;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wstate_q     <= W_IDLE;
      spec_ptr_q   <= '0;
      commit_ptr_q <= '0;
      wcnt_q       <= '0;
      drop_cnt_q   <= '0;
    end else begin
      unique case (wstate_q)
        W_IDLE: begin
          if (wr_store)    wstate_q <= W_RECV;
          else if (wr_ovf) wstate_q <= W_DROP;
        end
        W_RECV: if (wr_ovf) wstate_q <= W_DROP;
        W_DROP: ;
      endcase
      spec_ptr_q <= spec_n;
      wcnt_q     <= wcnt_n;
      if (bus.fin_udp) begin
        wstate_q <= W_IDLE;
        wcnt_q   <= '0;
        if (commit) begin
          commit_ptr_q <= spec_n;
        end else begin
          spec_ptr_q <= commit_ptr_q;
          if (drop_cnt_q != DROP_CNT_MAX)
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
      end
    end
  end

  // the IDLE rd_en already fetches word 0
  always_comb begin
    rd_fire = bus.rd_en && !desc_empty;
    remain  = (rstate_q == R_IDLE) ? head.wcnt : rcnt_q;
    pop     = rd_fire && (remain <= 16'd1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rstate_q   <= R_IDLE;
      rd_ptr_q   <= '0;
      rcnt_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      rd_valid_q <= rd_fire;
      rd_last_q  <= pop;
      if (rd_fire) begin
        if (remain == 16'd0) begin
          rd_data_q <= '0;
        end else begin
          rd_data_q <= ram_q[rd_ptr_q[DEPTH_LOG2-1:0]];
          rd_ptr_q  <= rd_ptr_q + ONE;
          if (remain == 16'd1) begin
            rstate_q <= R_IDLE;
          end else begin
            rstate_q <= R_STREAM;
            rcnt_q   <= remain - 16'd1;
          end
        end
      end
    end
  end

  udp_rx_desc_fifo #(
    .DESC_LOG2 (DESC_LOG2)
  ) u_desc (
    .clk     (clk),
    .reset   (reset),
    .push_i  (commit),
    .din_i   (push_desc),
    .pop_i   (pop),
    .full_o  (desc_full),
    .empty_o (desc_empty),
    .head_o  (head)
  );

  assign bus.rd_data      = rd_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_last      = rd_last_q;
  assign bus.rd_len       = head.len;
  assign bus.rd_src_port  = head.src;
  assign bus.rd_dest_port = head.dst;
  assign bus.pkt_avail    = !desc_empty;
  assign bus.drop_cnt     = drop_cnt_q;

endmodule

// File: doc/udp_rx_buffer.md
# udp_rx_buffer

Packet buffer downstream of the combined IP/TCP/UDP decoder's UDP output. Stores UDP payload words as they arrive, commits a packet only when the decoder signals a good end-of-packet, and rolls back bad or overflowing packets. The application side then reads whole packets with their length and ports.

## Interface
Parameters:
- `DEPTH_LOG2`, 9: payload RAM holds 2^DEPTH_LOG2 32-bit words.
- `DESC_LOG2`, 3: descriptor FIFO holds 2^DESC_LOG2 committed packets.
- `LOCAL_PORT`, 16'h2694: accepted destination port, used only with the port filter.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `data_udp_out`  in  32  payload word from the decoder; big-endian byte order.
- `wr_en_udp`  in  1  `data_udp_out` valid this cycle.
- `len_udp_data`  in  16  payload byte count; stable while `fin_udp`=1.
- `src_port_udp`, `dest_port_udp`  in  16 each  ports; stable while `fin_udp`=1.
- `ok_udp`  in  1  sampled with `fin_udp`; 1 = packet good.
- `fin_udp`  in  1  one-cycle end-of-packet pulse.
- `rd_en`  in  1  request next word of the head packet.
- `rd_data`  out  32  payload word.
- `rd_valid`  out  1  `rd_data` valid.
- `rd_last`  out  1  last word of the packet; qualified by `rd_valid`.
- `rd_len`, `rd_src_port`, `rd_dest_port`  out  16 each  head-packet descriptor; valid while `pkt_avail`=1.
- `pkt_avail`  out  1  at least one committed packet is available.
- `drop_cnt`  out  16  saturating count of dropped packets.

## Operation
- Write side FSM has three states: IDLE, RECV, DROP.
  - IDLE to RECV on the first `wr_en_udp`.
  - RECV stores each word at `spec_ptr` and increments it. It also counts words into `wcnt`.
  - RECV to DROP when a write arrives with `spec_ptr - rd_ptr == 2^DEPTH_LOG2` (RAM full). The word that would overflow is not written.
  - DROP ignores further writes.
- `fin_udp` is accepted in any state and returns the write FSM to IDLE.
  - Commit happens when: `ok_udp`=1, state is not DROP, and the descriptor FIFO is not full. Commit sets `commit_ptr = spec_ptr` and pushes {len, src, dst, wcnt}.
  - Otherwise the packet is rolled back: `spec_ptr = commit_ptr`, and `drop_cnt` increments, saturating at 16'hFFFF.
- A `fin_udp` with no preceding writes commits a zero-word descriptor.
- `wr_en_udp` and `fin_udp` in the same cycle: the word is stored first, then the fin is evaluated including that word.
- Read side FSM has two states: IDLE and STREAM.
  - `rd_en` with `pkt_avail`=1 in IDLE loads `rcnt = wcnt` and enters STREAM.
  - Each `rd_en` in STREAM reads `rd_ptr` and increments it.
  - When the last word is read, the descriptor is popped and the FSM returns to IDLE.
  - `rd_en` is ignored when `pkt_avail`=0.
- Zero-word packet: a single `rd_en` gives `rd_valid`=1, `rd_last`=1, `rd_data`=0, and pops the descriptor.
- Pointers are DEPTH_LOG2+1 bits, wrap modulo 2^(DEPTH_LOG2+1), and the RAM is addressed by the low bits.
- Reads only ever touch committed data, so a commit and a read in the same cycle are both legal.
- Reset clears all pointers, both FSMs, the descriptor FIFO and `drop_cnt`. Any packet in progress is lost and is not counted.

## Timing
- Synchronous RAM read: `rd_data`, `rd_valid` and `rd_last` appear one cycle after the accepted `rd_en`.
- Full throughput of one word per cycle on both sides.
- `pkt_avail` rises the cycle after the committing `fin_udp`.
- `pkt_avail` falls the cycle after the final `rd_en` if no further packet is queued.
- Reset values:
  - `rd_data`=0, `rd_valid`=0, `rd_last`=0.
  - `pkt_avail`=0.
  - `rd_len`, `rd_src_port`, `rd_dest_port` = 0.
  - `drop_cnt`=0.

## Configuration
- `UDP_RX_PORT_FILTER_EN` defined: a packet whose `dest_port_udp != LOCAL_PORT` at `fin_udp` is treated as `ok_udp`=0, so it is rolled back and counted in `drop_cnt`.
- Undefined: all ports are accepted and `LOCAL_PORT` is unused.

## Structure
- Package `udp_rx_pkg`:
  - descriptor struct {len, src, dst, wcnt};
  - write-FSM and read-FSM state enums;
  - constant `DROP_CNT_MAX`.
- Sub-module `udp_rx_desc_fifo`: synchronous descriptor FIFO with push, pop, full, empty and a show-ahead head output.

## Test plan
- 11-byte payload "Hello World" in 3 words, `ok_udp`=1, `len`=11 → `pkt_avail`=1. Three `rd_en` give 48656C6C, 6F20576F, 726C6400. `rd_last` on the third; `rd_len`=11.
- Same packet with `ok_udp`=0 → `pkt_avail` stays 0, `drop_cnt`=1, and a following good packet reads back correctly from the same addresses.
- `DEPTH_LOG2`=2 and a 6-word packet → DROP state, `drop_cnt`=1. A following 4-word packet commits and fills the RAM exactly.
- 9 good packets with `DESC_LOG2`=3 and no reads → the 9th is dropped and `drop_cnt`=1. Draining returns 8 packets in order.
- Reads of packet A overlapping the write and commit of packet B, with pointer wrap → both read intact. Assert `reset` mid-stream → all outputs return to reset values asynchronously.
- With the filter defined: `dest_port_udp`=16'h1111 → dropped; 16'h2694 → committed.
